// File: rtl/encoder_8to3_serial_pkg.sv
// ============================================================================
// encoder_8to3_serial_pkg: shared widths and FSM state encoding
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package encoder_8to3_serial_pkg;

  localparam int WIDTH = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/encoder_8to3_serial.sv
// ============================================================================
// encoder_8to3_serial: bit-serial 8-to-3 priority encoder with empty and
// multi-hot flags, valid/ready handshakes on input and output.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module encoder_8to3_serial
  import encoder_8to3_serial_pkg::*;
#(
  parameter bit PRIORITY_HIGH = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_none,
  output logic             out_multi
);

  state_t           state;
  logic [WIDTH-1:0] vec;
  logic [IDX_W-1:0] cnt;
  logic             found;
  logic [IDX_W-1:0] bit_sel;

  // Scanning from the top is the same counter, bit-inverted (7 - cnt).
  assign bit_sel = PRIORITY_HIGH ? ~cnt : cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_none  <= 1'b0;
      out_multi <= 1'b0;
      vec       <= '0;
      cnt       <= '0;
      found     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            vec       <= in_vec;
            out_idx   <= '0;
            out_none  <= (in_vec == '0);
            out_multi <= 1'b0;
            found     <= 1'b0;
            cnt       <= '0;
            in_ready  <= 1'b0;
            state     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (vec[bit_sel]) begin
            if (!found) begin
              out_idx <= bit_sel;
              found   <= 1'b1;
            end else begin
              out_multi <= 1'b1;
            end
          end
          cnt <= cnt + 3'd1;
          // Fixed-length scan: always all eight bits, so latency never varies.
          if (cnt == 3'd7) begin
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
